// File: rtl/disjoint_switch_box_cfg.sv
// disjoint_switch_box_cfg: disjoint switch box with multi-beat double-buffered config.
// Define SWITCH_BOX_OUT_REG_EN to register the four *_out buses.
module disjoint_switch_box_cfg #(
  parameter int W = 8,
  parameter int CFG_WORD = 16,
  parameter int CONF_WIDTH = 8*W,
  parameter int NBEATS = (CONF_WIDTH + CFG_WORD - 1) / CFG_WORD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CFG_WORD-1:0] cfg_data,
  input  logic                cfg_abort,
  input  logic                cfg_commit,
  output logic                cfg_done,
  output logic                cfg_err,
  output logic                cfg_loaded,
  input  logic [W-1:0]        north_in,
  input  logic [W-1:0]        east_in,
  input  logic [W-1:0]        south_in,
  input  logic [W-1:0]        west_in,
  output logic [W-1:0]        north_out,
  output logic [W-1:0]        east_out,
  output logic [W-1:0]        south_out,
  output logic [W-1:0]        west_out
);
  localparam int KW = NBEATS > 1 ? $clog2(NBEATS) : 1;
  typedef enum logic [1:0] {IDLE, LOADING, LOADED} state_t;
  state_t state, state_nxt;
  logic [KW-1:0] k, k_nxt;
  logic [CONF_WIDTH-1:0] shadow, active;
  logic accept, last, apply, reject;
  logic [W-1:0] rn, re, rs, rw;
  assign cfg_ready = state != LOADED;
  assign cfg_loaded = state == LOADED;
  always_comb begin
    accept = cfg_valid && cfg_ready && !cfg_abort;
    last = k == KW'(NBEATS - 1);
    apply = !cfg_abort && cfg_commit && state == LOADED;
    reject = !cfg_abort && cfg_commit && state != LOADED;
    state_nxt = cfg_abort || apply ? IDLE : accept ? (last ? LOADED : LOADING) : state;
    k_nxt = cfg_abort || (accept && last) ? '0 : accept ? k + KW'(1) : k;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      shadow <= '0;
      active <= '0;
      cfg_done <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state <= state_nxt;
      k <= k_nxt;
      cfg_done <= apply;
      cfg_err <= reject;
      if (apply) active <= shadow;
      // padding bits of the final beat fall past CONF_WIDTH and are dropped
      if (accept)
        for (int b = 0; b < CFG_WORD; b++)
          if (int'(k) * CFG_WORD + b < CONF_WIDTH) shadow[int'(k) * CFG_WORD + b] <= cfg_data[b];
    end
  end
  function automatic logic pick(input logic [1:0] s, input logic a, input logic b, input logic c);
    return s == 2'd1 ? a : s == 2'd2 ? b : s == 2'd3 ? c : 1'b0;
  endfunction
  for (genvar i = 0; i < W; i++) begin : g_track
    assign rn[i] = pick(active[8*i +: 2], east_in[i], south_in[i], west_in[i]);
    assign re[i] = pick(active[8*i+2 +: 2], south_in[i], west_in[i], north_in[i]);
    assign rs[i] = pick(active[8*i+4 +: 2], west_in[i], north_in[i], east_in[i]);
    assign rw[i] = pick(active[8*i+6 +: 2], north_in[i], east_in[i], south_in[i]);
  end
`ifdef SWITCH_BOX_OUT_REG_EN
  always_ff @(posedge clk) begin
    if (rst) {north_out, east_out, south_out, west_out} <= '0;
    else {north_out, east_out, south_out, west_out} <= {rn, re, rs, rw};
  end
`else
  assign {north_out, east_out, south_out, west_out} = {rn, re, rs, rw};
`endif
endmodule

// File: tb/tb_disjoint_switch_box_cfg.sv
// tb_disjoint_switch_box_cfg: scoreboard bench against a side-rotation reference model.
module tb_disjoint_switch_box_cfg;
  localparam int W = 8;
  localparam int CFG_WORD = 16;
  localparam int CW = 8 * W;
  localparam int NB = (CW + CFG_WORD - 1) / CFG_WORD;
  logic clk = 1'b0, rst = 1'b1, cfg_valid = 1'b0, cfg_abort = 1'b0, cfg_commit = 1'b0;
  logic [CFG_WORD-1:0] cfg_data = '0;
  logic cfg_ready, cfg_done, cfg_err, cfg_loaded;
  logic [W-1:0] ni = '1, ei = '1, si = '1, wi = '1;
  logic [W-1:0] north_out, east_out, south_out, west_out;
  disjoint_switch_box_cfg #(.W(W), .CFG_WORD(CFG_WORD)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .cfg_abort(cfg_abort), .cfg_commit(cfg_commit), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .cfg_loaded(cfg_loaded), .north_in(ni), .east_in(ei), .south_in(si), .west_in(wi),
    .north_out(north_out), .east_out(east_out), .south_out(south_out), .west_out(west_out));
  always #5 clk = ~clk;
  typedef struct { logic [W-1:0] n, e, s, w; logic rdy, ld, dn, er; } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  bit [CW-1:0] m_act, m_sh;
  bit [4*W-1:0] m_prev;
  int m_k;
  bit m_loaded, m_done, m_err, m_ok, rand_in;
  // sides 0..3 = N,E,S,W; a nonzero select s on side o picks side (o+s) mod 4
  function automatic bit [4*W-1:0] route(bit [CW-1:0] act, bit [W-1:0] n, bit [W-1:0] e, bit [W-1:0] s, bit [W-1:0] w);
    bit [W-1:0] ins[4];
    bit [4*W-1:0] r;
    int sel;
    ins[0] = n; ins[1] = e; ins[2] = s; ins[3] = w;
    r = '0;
    for (int o = 0; o < 4; o++)
      for (int i = 0; i < W; i++) begin
        sel = int'(act[8*i + 2*o +: 2]);
        if (sel != 0) r[o*W + i] = ins[(o + sel) % 4][i];
      end
    return r;
  endfunction
  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin : mon
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("north_out", north_out, x.n);
      chk("east_out", east_out, x.e);
      chk("south_out", south_out, x.s);
      chk("west_out", west_out, x.w);
      chk("cfg_ready", W'(cfg_ready), W'(x.rdy));
      chk("cfg_loaded", W'(cfg_loaded), W'(x.ld));
      chk("cfg_done", W'(cfg_done), W'(x.dn));
      chk("cfg_err", W'(cfg_err), W'(x.er));
    end
  end
  task automatic cyc(input bit r, input bit v, input bit [CFG_WORD-1:0] d, input bit ab, input bit cm);
    exp_t x;
    bit [4*W-1:0] o, now;
    rst = r; cfg_valid = v; cfg_data = d; cfg_abort = ab; cfg_commit = cm;
    if (rand_in) begin
      ni = W'($urandom()); ei = W'($urandom()); si = W'($urandom()); wi = W'($urandom());
    end
    now = route(m_act, ni, ei, si, wi);
`ifdef SWITCH_BOX_OUT_REG_EN
    o = m_prev;
`else
    o = now;
`endif
    if (m_ok) begin
      x.n = o[W-1:0]; x.e = o[2*W-1:W]; x.s = o[3*W-1:2*W]; x.w = o[4*W-1:3*W];
      x.rdy = !m_loaded; x.ld = m_loaded; x.dn = m_done; x.er = m_err;
      q.push_back(x);
    end
    @(posedge clk);
    if (r) begin
      m_act = '0; m_sh = '0; m_prev = '0; m_k = 0; m_loaded = 0; m_done = 0; m_err = 0; m_ok = 1;
    end else begin
      bit was_loaded;
      was_loaded = m_loaded;
      m_prev = now;
      m_done = 0; m_err = 0;
      if (ab) begin
        m_loaded = 0; m_k = 0;
      end else begin
        if (cm && was_loaded) begin m_act = m_sh; m_loaded = 0; m_done = 1; end
        else if (cm) m_err = 1;
        if (v && !was_loaded) begin
          for (int b = 0; b < CFG_WORD; b++)
            if (m_k * CFG_WORD + b < CW) m_sh[m_k * CFG_WORD + b] = d[b];
          m_k++;
          if (m_k == NB) begin m_loaded = 1; m_k = 0; end
        end
      end
    end
    #1;
  endtask
  task automatic beats(input int n, input bit [CFG_WORD-1:0] d);
    for (int i = 0; i < n; i++) cyc(0, 1, d, 0, 0);
  endtask
  task automatic rbeats(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, CFG_WORD'($urandom()), 0, 0);
  endtask
  initial begin
    rand_in = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    ni = 8'hA5; ei = '0; si = '0; wi = '0;
    beats(4, 16'h5555);
    cyc(0, 0, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 0);
    rand_in = 1;
    for (int i = 0; i < 6; i++) cyc(0, 1, CFG_WORD'($urandom()), 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    rbeats(2);
    cyc(0, 0, 0, 0, 1);
    rbeats(2);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    rbeats(3);
    cyc(0, 0, 0, 1, 0);
    beats(4, 16'hFFFF);
    cyc(0, 0, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 0);
    rbeats(2);
    cyc(1, 0, 0, 0, 0);
    rbeats(4);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    rbeats(2);
    cyc(0, 1, CFG_WORD'($urandom()), 1, 0);
    rbeats(3);
    cyc(0, 1, CFG_WORD'($urandom()), 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 500; i++)
      cyc($urandom_range(63) == 0, $urandom_range(3) != 0, CFG_WORD'($urandom()),
          $urandom_range(15) == 0, $urandom_range(5) == 0);
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
